hazard_ctrl: RTL and testbench

Central pipeline sequencer for the 5-stage MIPS pipeline. It drives the load-enable and flush (bubble) inputs of PC, IF_ID, ID_EX, EX_MEM and MEM_WB. It resolves four hazard classes:
- load-use data hazards
- EX-stage control redirects
- multi-cycle HI/LO (mul/div) occupancy
- syscall halt/resume

It also keeps a stall-cycle statistics counter.

---
 rtl/hazard_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_hazard_ctrl.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_ctrl
//
// Central sequencer for a 5-stage MIPS pipeline. Every cycle it decides which
// pipeline registers load, which are cleared to a bubble, and whether the core
// is halted. Four hazard classes are resolved, highest priority first:
//   halt (syscall with $v0 == 10), EX redirect, multi-cycle mul/div occupancy,
//   and load-use. A statistics counter tallies cycles in which the PC is held
//   outside of HALT.
//
// All control outputs are combinational from the current state and inputs, so
// a decision takes effect on the very next rising edge.
//
// Ports
//   clk, rst                  clock, asynchronous active-high reset
//   id_rs_num/used            ID source register 1 and its use flag
//   id_rt_num/used            ID source register 2 and its use flag
//   ex_ld, ex_write_num,
//   ex_regwrite               EX destination info for load-use detection
//   ex_redirect               EX resolved a taken branch/jump
//   ex_mdu_start              EX holds a multi-cycle mul/div
//   ex_syscall, ex_v0         EX holds a syscall and its forwarded $v0
//   resume                    single-cycle pulse that leaves HALT
//   pc_en, *_en, *_flush      pipeline register load enables / bubble inserts
//   halted                    core is in HALT
//   stall_cycles              count of cycles with pc_en=0 outside HALT
// ---------------------------------------------------------------------------
module hazard_ctrl #(
    parameter int REG_BITS = 6,
    parameter int MDU_LAT  = 4,
    parameter int CNT_BITS = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [REG_BITS-1:0] id_rs_num,
    input  logic                id_rs_used,
    input  logic [REG_BITS-1:0] id_rt_num,
    input  logic                id_rt_used,
    input  logic                ex_ld,
    input  logic [REG_BITS-1:0] ex_write_num,
    input  logic                ex_regwrite,
    input  logic                ex_redirect,
    input  logic                ex_mdu_start,
    input  logic                ex_syscall,
    input  logic [31:0]         ex_v0,
    input  logic                resume,
    output logic                pc_en,
    output logic                if_id_en,
    output logic                if_id_flush,
    output logic                id_ex_en,
    output logic                id_ex_flush,
    output logic                ex_mem_en,
    output logic                ex_mem_flush,
    output logic                mem_wb_en,
    output logic                halted,
    output logic [CNT_BITS-1:0] stall_cycles
);

    // The down-counter only has to reach MDU_LAT-2; keep it at least one bit
    // wide so MDU_LAT == 1 still elaborates.
    localparam int CW = (MDU_LAT > 1) ? $clog2(MDU_LAT) : 1;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MDU_WAIT = 2'd1,
        HALT     = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [CW-1:0]       cnt_q,   cnt_d;
    logic [CNT_BITS-1:0] stall_q, stall_d;

    logic luse;
    logic halt_req;

    // Register 0 is hard-wired to zero, so a load targeting it never hazards.
    assign luse = ex_ld && ex_regwrite && (ex_write_num != '0) &&
                  ((id_rs_used && (id_rs_num == ex_write_num)) ||
                   (id_rt_used && (id_rt_num == ex_write_num)));

    assign halt_req = ex_syscall && (ex_v0 == 32'd10);

    // -----------------------------------------------------------------------
    // Next-state and output decode
    // -----------------------------------------------------------------------
    // NOTE: every signal driven here gets a default first so no path can
    // leave it unassigned; a missing default would infer a latch.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        pc_en        = 1'b1;
        if_id_en     = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_en     = 1'b1;
        id_ex_flush  = 1'b0;
        ex_mem_en    = 1'b1;
        ex_mem_flush = 1'b0;
        mem_wb_en    = 1'b1;
        halted       = 1'b0;

        unique case (state_q)
            RUN: begin
                if (halt_req) begin
                    // Freeze the front end with the syscall parked in ID_EX;
                    // EX_MEM holds rather than bubbles on this one cycle.
                    pc_en     = 1'b0;
                    if_id_en  = 1'b0;
                    id_ex_en  = 1'b0;
                    ex_mem_en = 1'b0;
                    state_d   = HALT;
                end else if (ex_redirect) begin
                    // Squash the two wrong-path instructions behind the jump.
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                end else if (ex_mdu_start && (MDU_LAT > 1)) begin
                    pc_en        = 1'b0;
                    if_id_en     = 1'b0;
                    id_ex_en     = 1'b0;
                    ex_mem_flush = 1'b1;
                    // This cycle and MDU_LAT-2 more stall, then one release.
                    cnt_d        = CW'(MDU_LAT - 2);
                    state_d      = MDU_WAIT;
                end else if (luse) begin
                    pc_en       = 1'b0;
                    if_id_en    = 1'b0;
                    id_ex_flush = 1'b1;
                end
            end

            MDU_WAIT: begin
                if (cnt_q != '0) begin
                    pc_en        = 1'b0;
                    if_id_en     = 1'b0;
                    id_ex_en     = 1'b0;
                    ex_mem_flush = 1'b1;
                    cnt_d        = cnt_q - CW'(1);
                end else begin
                    // Release: defaults let the mul/div leave EX untouched by
                    // any hazard that would otherwise retrigger on it.
                    state_d = RUN;
                end
            end

            HALT: begin
                halted = 1'b1;
                if (resume) begin
                    // Release cycle with defaults so the parked syscall moves
                    // on instead of re-entering HALT.
                    state_d = RUN;
                end else begin
                    pc_en        = 1'b0;
                    if_id_en     = 1'b0;
                    id_ex_en     = 1'b0;
                    ex_mem_en    = 1'b0;
                    ex_mem_flush = 1'b1;
                end
            end

            default: state_d = RUN;
        endcase

        // Reset overrides everything: hold every stage and clear bubbles in.
        if (rst) begin
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_en     = 1'b0;
            id_ex_flush  = 1'b1;
            ex_mem_en    = 1'b0;
            ex_mem_flush = 1'b1;
            mem_wb_en    = 1'b0;
            halted       = 1'b0;
        end
    end

    // Held cycles are counted in RUN and MDU_WAIT only; HALT is idle time.
    always_comb begin
        stall_d = stall_q;
        if (!pc_en && (state_q != HALT)) begin
            stall_d = stall_q + CNT_BITS'(1);
        end
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its pre-edge value; blocking here would create ordering races.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
            cnt_q   <= '0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            stall_q <= stall_d;
        end
    end

    assign stall_cycles = stall_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hazard_ctrl
//
// Two instances share one stimulus stream: one with a 4-cycle mul/div and one
// with a single-cycle mul/div, both with a 4-bit stall counter so wrap-around
// is reachable. The stimulus process drives inputs on the falling edge, runs
// a behavioural model of the pipeline sequencing rules and pushes the
// expected outputs of both instances into a scoreboard queue. A separate
// monitor pops the queue shortly after each falling edge and compares.
// ---------------------------------------------------------------------------
module tb_hazard_ctrl;

    localparam int RB = 6;
    localparam int CB = 4;

    typedef struct packed {
        logic          rst;
        logic [RB-1:0] rs_num;
        logic          rs_used;
        logic [RB-1:0] rt_num;
        logic          rt_used;
        logic          ld;
        logic [RB-1:0] wnum;
        logic          regwrite;
        logic          redirect;
        logic          mdu;
        logic          syscall;
        logic [31:0]   v0;
        logic          resume;
    } stim_t;

    typedef struct packed {
        logic          pc_en;
        logic          if_id_en;
        logic          if_id_flush;
        logic          id_ex_en;
        logic          id_ex_flush;
        logic          ex_mem_en;
        logic          ex_mem_flush;
        logic          mem_wb_en;
        logic          halted;
        logic [CB-1:0] stall;
    } outs_t;

    typedef struct packed {
        outs_t e4;
        outs_t e1;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [RB-1:0] id_rs_num = '0;
    logic          id_rs_used = 1'b0;
    logic [RB-1:0] id_rt_num = '0;
    logic          id_rt_used = 1'b0;
    logic          ex_ld = 1'b0;
    logic [RB-1:0] ex_write_num = '0;
    logic          ex_regwrite = 1'b0;
    logic          ex_redirect = 1'b0;
    logic          ex_mdu_start = 1'b0;
    logic          ex_syscall = 1'b0;
    logic [31:0]   ex_v0 = '0;
    logic          resume = 1'b0;

    logic          a_pc_en, a_if_id_en, a_if_id_flush, a_id_ex_en, a_id_ex_flush;
    logic          a_ex_mem_en, a_ex_mem_flush, a_mem_wb_en, a_halted;
    logic [CB-1:0] a_stall;
    logic          b_pc_en, b_if_id_en, b_if_id_flush, b_id_ex_en, b_id_ex_flush;
    logic          b_ex_mem_en, b_ex_mem_flush, b_mem_wb_en, b_halted;
    logic [CB-1:0] b_stall;

    outs_t act4, act1;
    assign act4 = {a_pc_en, a_if_id_en, a_if_id_flush, a_id_ex_en, a_id_ex_flush,
                   a_ex_mem_en, a_ex_mem_flush, a_mem_wb_en, a_halted, a_stall};
    assign act1 = {b_pc_en, b_if_id_en, b_if_id_flush, b_id_ex_en, b_id_ex_flush,
                   b_ex_mem_en, b_ex_mem_flush, b_mem_wb_en, b_halted, b_stall};

    hazard_ctrl #(.REG_BITS(RB), .MDU_LAT(4), .CNT_BITS(CB)) dut4 (
        .clk(clk), .rst(rst),
        .id_rs_num(id_rs_num), .id_rs_used(id_rs_used),
        .id_rt_num(id_rt_num), .id_rt_used(id_rt_used),
        .ex_ld(ex_ld), .ex_write_num(ex_write_num), .ex_regwrite(ex_regwrite),
        .ex_redirect(ex_redirect), .ex_mdu_start(ex_mdu_start),
        .ex_syscall(ex_syscall), .ex_v0(ex_v0), .resume(resume),
        .pc_en(a_pc_en), .if_id_en(a_if_id_en), .if_id_flush(a_if_id_flush),
        .id_ex_en(a_id_ex_en), .id_ex_flush(a_id_ex_flush),
        .ex_mem_en(a_ex_mem_en), .ex_mem_flush(a_ex_mem_flush),
        .mem_wb_en(a_mem_wb_en), .halted(a_halted), .stall_cycles(a_stall)
    );

    hazard_ctrl #(.REG_BITS(RB), .MDU_LAT(1), .CNT_BITS(CB)) dut1 (
        .clk(clk), .rst(rst),
        .id_rs_num(id_rs_num), .id_rs_used(id_rs_used),
        .id_rt_num(id_rt_num), .id_rt_used(id_rt_used),
        .ex_ld(ex_ld), .ex_write_num(ex_write_num), .ex_regwrite(ex_regwrite),
        .ex_redirect(ex_redirect), .ex_mdu_start(ex_mdu_start),
        .ex_syscall(ex_syscall), .ex_v0(ex_v0), .resume(resume),
        .pc_en(b_pc_en), .if_id_en(b_if_id_en), .if_id_flush(b_if_id_flush),
        .id_ex_en(b_id_ex_en), .id_ex_flush(b_id_ex_flush),
        .ex_mem_en(b_ex_mem_en), .ex_mem_flush(b_ex_mem_flush),
        .mem_wb_en(b_mem_wb_en), .halted(b_halted), .stall_cycles(b_stall)
    );

    always #5 clk = ~clk;

    int   n_vec = 0;
    int   n_err = 0;
    exp_t sb[$];

    // Reference model state, one slot per instance (0: 4-cycle, 1: 1-cycle).
    bit m_halt[2];
    bit m_busy[2];
    int m_age[2];     // EX cycles the mul/div has already spent
    int m_stalls[2];  // held-PC cycles, modulo 2^CB

    task automatic check(input string name, input outs_t act, input outs_t exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got pc/ifen/iffl/idexen/idexfl/exmen/exmfl/mwben/halt/stall=%b expected %b",
                     name, $time, act, exp);
        end
    endtask

    task automatic model_step(input stim_t s, input int k, input int lat, output outs_t e);
        bit luse;
        bit was_halt;
        luse = s.ld && s.regwrite && (s.wnum != 0) &&
               ((s.rs_used && s.rs_num == s.wnum) || (s.rt_used && s.rt_num == s.wnum));
        e = '0;
        if (s.rst) begin
            e.if_id_flush  = 1'b1;
            e.id_ex_flush  = 1'b1;
            e.ex_mem_flush = 1'b1;
            m_halt[k]   = 1'b0;
            m_busy[k]   = 1'b0;
            m_age[k]    = 0;
            m_stalls[k] = 0;
            return;
        end
        e.pc_en     = 1'b1;
        e.if_id_en  = 1'b1;
        e.id_ex_en  = 1'b1;
        e.ex_mem_en = 1'b1;
        e.mem_wb_en = 1'b1;
        e.stall     = CB'(m_stalls[k]);
        was_halt    = m_halt[k];
        if (m_halt[k]) begin
            e.halted = 1'b1;
            if (s.resume) begin
                m_halt[k] = 1'b0;
            end else begin
                e.pc_en = 0; e.if_id_en = 0; e.id_ex_en = 0; e.ex_mem_en = 0;
                e.ex_mem_flush = 1;
            end
        end else if (m_busy[k]) begin
            if (m_age[k] < lat - 1) begin
                e.pc_en = 0; e.if_id_en = 0; e.id_ex_en = 0; e.ex_mem_flush = 1;
                m_age[k]++;
            end else begin
                m_busy[k] = 1'b0;
            end
        end else if (s.syscall && s.v0 == 32'd10) begin
            e.pc_en = 0; e.if_id_en = 0; e.id_ex_en = 0; e.ex_mem_en = 0;
            m_halt[k] = 1'b1;
        end else if (s.redirect) begin
            e.if_id_flush = 1; e.id_ex_flush = 1;
        end else if (s.mdu && lat > 1) begin
            e.pc_en = 0; e.if_id_en = 0; e.id_ex_en = 0; e.ex_mem_flush = 1;
            m_busy[k] = 1'b1;
            m_age[k]  = 1;
        end else if (luse) begin
            e.pc_en = 0; e.if_id_en = 0; e.id_ex_flush = 1;
        end
        if (!was_halt && !e.pc_en) m_stalls[k] = (m_stalls[k] + 1) % (1 << CB);
    endtask

    task automatic apply(input stim_t s);
        exp_t e;
        @(negedge clk);
        rst          = s.rst;
        id_rs_num    = s.rs_num;
        id_rs_used   = s.rs_used;
        id_rt_num    = s.rt_num;
        id_rt_used   = s.rt_used;
        ex_ld        = s.ld;
        ex_write_num = s.wnum;
        ex_regwrite  = s.regwrite;
        ex_redirect  = s.redirect;
        ex_mdu_start = s.mdu;
        ex_syscall   = s.syscall;
        ex_v0        = s.v0;
        resume       = s.resume;
        model_step(s, 0, 4, e.e4);
        model_step(s, 1, 1, e.e1);
        sb.push_back(e);
    endtask

    function automatic stim_t rnd();
        stim_t s = '0;
        s.rs_num   = RB'($urandom_range(0, 3));
        s.rs_used  = 1'($urandom_range(0, 1));
        s.rt_num   = RB'($urandom_range(0, 3));
        s.rt_used  = 1'($urandom_range(0, 1));
        s.ld       = ($urandom_range(0, 2) == 0);
        s.wnum     = RB'($urandom_range(0, 3));
        s.regwrite = 1'($urandom_range(0, 1));
        s.redirect = ($urandom_range(0, 7) == 0);
        s.mdu      = !s.ld && ($urandom_range(0, 9) == 0);
        s.syscall  = ($urandom_range(0, 19) == 0);
        s.v0       = ($urandom_range(0, 1) == 1) ? 32'd10 : $urandom;
        s.resume   = ($urandom_range(0, 5) == 0);
        s.rst      = ($urandom_range(0, 199) == 0);
        return s;
    endfunction

    // Monitor: outputs are combinational, so one sample per cycle, 2 ns after
    // the inputs change on the falling edge and well before the rising edge.
    initial begin : monitor
        exp_t x;
        forever begin
            @(negedge clk);
            #2;
            if (sb.size() != 0) begin
                x = sb.pop_front();
                check("lat4", act4, x.e4);
                check("lat1", act1, x.e1);
            end
        end
    end

    initial begin : stimulus
        stim_t s;

        // Reset state
        s = '0; s.rst = 1'b1;
        apply(s); apply(s);

        // Load-use on $5, then the same load targeting $0
        s = '0; s.ld = 1; s.regwrite = 1; s.wnum = 5; s.rs_num = 5; s.rs_used = 1;
        apply(s);
        s = '0; apply(s);
        s = '0; s.ld = 1; s.regwrite = 1; s.wnum = 0; s.rs_num = 0; s.rs_used = 1;
        apply(s);
        s = '0; apply(s);

        // Redirect coinciding with a load-use
        s = '0; s.ld = 1; s.regwrite = 1; s.wnum = 3; s.rt_num = 3; s.rt_used = 1;
        s.redirect = 1;
        apply(s);
        s = '0; apply(s);

        // Mul/div held in EX for its full occupancy
        s = '0; s.mdu = 1;
        repeat (4) apply(s);
        s = '0; apply(s); apply(s);

        // Halt, 20 idle halted cycles, resume, then a non-exit syscall
        s = '0; s.syscall = 1; s.v0 = 32'd10;
        repeat (21) apply(s);
        s.resume = 1; apply(s);
        s = '0; apply(s); apply(s);
        s = '0; s.syscall = 1; s.v0 = 32'd1; apply(s);
        s = '0; apply(s);

        // Reset asserted in the second MDU_WAIT cycle
        s = '0; s.mdu = 1;
        apply(s); apply(s);
        s.rst = 1; apply(s);
        s = '0; apply(s); apply(s);

        // Counter wrap after 16 load-use stalls
        s = '0; s.rst = 1; apply(s);
        repeat (16) begin
            s = '0; s.ld = 1; s.regwrite = 1; s.wnum = 7; s.rs_num = 7; s.rs_used = 1;
            apply(s);
            s = '0; apply(s);
        end
        s = '0; apply(s);

        // Randomized traffic
        repeat (1500) apply(rnd());

        // Drain: the last pushed expectation must have been consumed.
        @(negedge clk);
        #4;
        n_vec++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d expectations left, required 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
